// File: rtl/wc_tile_loader_if.sv
// Sample-in / tile-out handshake bundle for wc_tile_loader.
// master drives samples and consumes tiles; slave is the loader.
interface wc_tile_loader_if #(
  parameter int unsigned W    = 10,
  parameter int unsigned TILE = 6
);
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [W*TILE-1:0] tile_data;
  logic              tile_valid;
  logic              tile_last;
  logic              tile_ready;

  modport master (
    output in_data, in_valid, in_last, tile_ready,
    input  in_ready, tile_data, tile_valid, tile_last
  );

  modport slave (
    input  in_data, in_valid, in_last, tile_ready,
    output in_ready, tile_data, tile_valid, tile_last
  );
endinterface

// File: rtl/wc_tile_loader.sv
// Assembles overlapping Winograd input tiles (TILE = M+R-1, stride M) from a sample stream.
// Optional macro WC_TILE_LEFT_PAD_EN pre-loads (R-1)/2 zero samples at the start of each row.
module wc_tile_loader #(
  parameter int unsigned W = 10,
  parameter int unsigned M = 2,
  parameter int unsigned R = 5
) (
  input  logic            clk,
  input  logic            rst,
  wc_tile_loader_if.slave bus
);
  localparam int unsigned TILE = M + R - 1;
  localparam int unsigned CW   = $clog2(TILE + 1);
`ifdef WC_TILE_LEFT_PAD_EN
  localparam int unsigned LPAD = (R - 1) / 2;
`else
  localparam int unsigned LPAD = 0;
`endif

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] STEADY = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] EMIT   = 2'd3;

  logic [1:0]               state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [CW-1:0]            pad, pad_n;
  logic [TILE-1:0][W-1:0]   win, win_n;
  logic                     last, last_n;
  logic                     ready, valid;
  logic                     accept;
  logic [CW-1:0]            cnt_inc;

  assign accept  = bus.in_valid && ready;
  assign cnt_inc = cnt + CW'(1);

  // Next-state: FILL counts a full window, STEADY counts one stride, FLUSH shifts in zeros.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pad_n   = pad;
    win_n   = win;
    last_n  = last;
    case (state)
      FILL: begin
        if (accept) begin
          win_n = {bus.in_data, win[TILE-1:1]};
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(TILE)) begin
            state_n = EMIT;
            last_n  = bus.in_last;
          end else if (bus.in_last) begin
            state_n = FLUSH;
            pad_n   = CW'(TILE) - cnt_inc;
          end
        end
      end
      STEADY: begin
        if (accept) begin
          win_n = {bus.in_data, win[TILE-1:1]};
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(M)) begin
            state_n = EMIT;
            last_n  = bus.in_last;
          end else if (bus.in_last) begin
            state_n = FLUSH;
            pad_n   = CW'(M) - cnt_inc;
          end
        end
      end
      FLUSH: begin
        win_n = {W'(0), win[TILE-1:1]};
        pad_n = pad - CW'(1);
        if (pad == CW'(1)) begin
          state_n = EMIT;
          last_n  = 1'b1;
        end
      end
      EMIT: begin
        if (bus.tile_ready) begin
          if (last) begin
            state_n = FILL;
            win_n   = '0;
            cnt_n   = CW'(LPAD);
            last_n  = 1'b0;
          end else begin
            state_n = STEADY;
            cnt_n   = '0;
          end
        end
      end
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
      cnt   <= CW'(LPAD);
      pad   <= '0;
      win   <= '0;
      last  <= 1'b0;
      ready <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pad   <= pad_n;
      win   <= win_n;
      last  <= last_n;
      ready <= (state_n == FILL) || (state_n == STEADY);
      valid <= (state_n == EMIT);
    end
  end

  assign bus.in_ready   = ready;
  assign bus.tile_valid = valid;
  assign bus.tile_last  = last;
  assign bus.tile_data  = win;
endmodule

// File: tb/tb_wc_tile_loader.sv
// Self-checking bench for wc_tile_loader: directed rows plus randomized rows against a tile model.
module tb_wc_tile_loader;
  localparam int W    = 10;
  localparam int M    = 2;
  localparam int R    = 5;
  localparam int TILE = M + R - 1;
  localparam int DW   = W * TILE;
`ifdef WC_TILE_LEFT_PAD_EN
  localparam int LPAD = (R - 1) / 2;
`else
  localparam int LPAD = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wc_tile_loader_if #(.W(W), .TILE(TILE)) bus();

  wc_tile_loader #(.W(W), .M(M), .R(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q[$];
  logic          exp_l[$];
  logic [W-1:0]  row_q[$];
  logic          rdy_rand = 1'b0;
  logic          held = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slide a TILE window by M over the (optionally left-padded) row, zero-extending the tail.
  function automatic int model_row();
    logic [W-1:0]  p[$];
    logic [DW-1:0] t;
    int n, nt, off;
    p = {};
    for (int i = 0; i < LPAD; i++) p.push_back('0);
    foreach (row_q[i]) p.push_back(row_q[i]);
    n  = p.size();
    nt = (n <= TILE) ? 1 : 1 + (n - TILE + M - 1) / M;
    for (int k = 0; k < nt; k++) begin
      off = k * M;
      t   = '0;
      for (int i = 0; i < TILE; i++)
        if (off + i < n) t[W*i +: W] = p[off + i];
      exp_q.push_back(t);
      exp_l.push_back(k == nt - 1);
    end
    return (nt - 1) * M + TILE - n;
  endfunction

  // Last TILE entries of the padded sequence 1..n.
  function automatic logic [DW-1:0] last_window(input int n);
    logic [DW-1:0] t;
    int tot, idx;
    t   = '0;
    tot = LPAD + n;
    for (int i = 0; i < TILE; i++) begin
      idx = tot - TILE + i;
      t[W*i +: W] = (idx < LPAD) ? W'(0) : W'(idx - LPAD + 1);
    end
    return t;
  endfunction

  task automatic push(input logic [W-1:0] d, input logic l);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready", DW'(bus.in_ready), DW'(1'b1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_row(input int len, input int base, input bit rnd);
    int pads, c;
    row_q = {};
    for (int k = 0; k < len; k++) row_q.push_back(rnd ? W'($urandom) : W'(base + k));
    pads = model_row();
    for (int k = 0; k < len; k++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      push(row_q[k], k == len - 1);
    end
    c = 0;
    @(negedge clk);
    while (!bus.tile_valid && c < 50) begin
      c++;
      @(negedge clk);
    end
    chk("pad_cycles", DW'(c), DW'(pads));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
    @(posedge clk);
    #1;
  endtask

  // Tile monitor: scoreboard on handshake, stability while stalled, no input acceptance in EMIT.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.tile_valid) begin
        chk("in_ready_in_emit", DW'(bus.in_ready), DW'(1'b0));
        if (held) begin
          chk("hold_data", bus.tile_data, held_data);
          chk("hold_last", DW'(bus.tile_last), DW'(held_last));
        end
        if (bus.tile_ready) begin
          if (exp_q.size() == 0) chk("tile_expected", DW'(exp_q.size()), DW'(1));
          else begin
            chk("tile_data", bus.tile_data, exp_q.pop_front());
            chk("tile_last", DW'(bus.tile_last), DW'(exp_l.pop_front()));
          end
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = bus.tile_data;
          held_last = bus.tile_last;
        end
      end else held = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) bus.tile_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.tile_ready = 1'b1;
    rst            = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tile_valid", DW'(bus.tile_valid), DW'(1'b0));
    chk("rst_tile_last", DW'(bus.tile_last), DW'(1'b0));
    chk("rst_tile_data", bus.tile_data, DW'(0));
    chk("rst_in_ready", DW'(bus.in_ready), DW'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_before_edge", DW'(bus.in_ready), DW'(1'b0));
    @(negedge clk);
    chk("in_ready_rise", DW'(bus.in_ready), DW'(1'b1));
    @(posedge clk);
    #1;

    // Row with one flush pad, row ending exactly on a stride, short row then clean next row.
    send_row(9, 1, 0);
    wait_drain();
    send_row(8, 1, 0);
    wait_drain();
    send_row(3, 1, 0);
    wait_drain();
    send_row(6, 11, 0);
    wait_drain();

    // Backpressure on the first tile for 5 cycles.
    bus.tile_ready = 1'b0;
    fork
      send_row(9, 1, 0);
      begin
        int t;
        t = 0;
        while (!bus.tile_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        repeat (5) @(posedge clk);
        #1;
        bus.tile_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset while holding the second tile of a row.
    for (int k = 1; k <= TILE - LPAD; k++) push(W'(k), 1'b0);
    exp_q.push_back(last_window(TILE - LPAD));
    exp_l.push_back(1'b0);
    wait_drain();
    bus.tile_ready = 1'b0;
    for (int k = 1; k <= M; k++) push(W'(TILE - LPAD + k), 1'b0);
    @(negedge clk);
    chk("emit_valid", DW'(bus.tile_valid), DW'(1'b1));
    chk("emit_data", bus.tile_data, last_window(TILE - LPAD + M));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.tile_ready = 1'b1;
    @(negedge clk);
    chk("rst_emit_valid", DW'(bus.tile_valid), DW'(1'b0));
    chk("rst_emit_in_ready", DW'(bus.in_ready), DW'(1'b0));
    chk("rst_emit_data", bus.tile_data, DW'(0));
    chk("rst_emit_last", DW'(bus.tile_last), DW'(1'b0));
    @(negedge clk);
    chk("rst_emit_ready_rise", DW'(bus.in_ready), DW'(1'b1));
    @(posedge clk);
    #1;
    send_row(6, 21, 0);
    wait_drain();

    // Randomized rows, data, input gaps and consumer backpressure.
    rdy_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      send_row($urandom_range(1, 14), 0, 1);
      wait_drain();
    end
    rdy_rand       = 1'b0;
    bus.tile_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
